// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier family: FSM states,
// recoded-digit encoding and the iteration-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Digit value is (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;

  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_radix4_recoder.sv
// Radix-4 Booth recoder: 3-bit multiplier window {q1,q0,qm1} to a signed digit.
module booth_radix4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output digit_t     digit
);

  always_comb begin
    digit = '0;
    case (window)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011:         digit.two = 1'b1;
      3'b100:         begin digit.neg = 1'b1; digit.two = 1'b1; end
      3'b101, 3'b110: begin digit.neg = 1'b1; digit.one = 1'b1; end
      default:        digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle,
// signed/unsigned mode and start/ready/done handshake.
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = booth_iters(WIDTH);
  localparam int EW = WIDTH + 2;  // extended operand width
  localparam int AW = WIDTH + 4;  // accumulator width, headroom for +/-2*M
  localparam int CW = $clog2(N + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] acc;
  logic [EW-1:0] q;
  logic [EW-1:0] m;
  logic          qm1;

  digit_t        dig;
  logic [AW-1:0] m_wide;
  logic [AW-1:0] sum;
  logic [AW-1:0] acc_next;
  logic [EW-1:0] q_next;

  booth_radix4_recoder u_rec (
    .window ({q[1:0], qm1}),
    .digit  (dig)
  );

  function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
    return s ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
  endfunction

  always_comb begin
    m_wide = '0;
    if (dig.two)      m_wide = {m[EW-1], m, 1'b0};
    else if (dig.one) m_wide = {{2{m[EW-1]}}, m};
    sum      = dig.neg ? acc - m_wide : acc + m_wide;
    // {A,Q} arithmetic shift right by 2; the two bits leaving A enter Q
    acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_next   = {sum[1:0], q[EW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      qm1     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            ready <= 1'b0;
            m     <= extend(multiplicand, signed_mode);
            q     <= extend(multiplier, signed_mode);
            acc   <= '0;
            qm1   <= 1'b0;
            count <= CW'(N);
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        CALC: begin
          acc   <= acc_next;
          q     <= q_next;
          qm1   <= q[1];
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state   <= DONE;
            done    <= 1'b1;
            ready   <= 1'b1;
            product <= {acc_next[WIDTH-3:0], q_next};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed self-checking bench for booth_radix4_multiplier at WIDTH=16.
module tb_booth_radix4_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        ready;
  logic        done;
  logic [31:0] product;

  int errors = 0;
  int checks = 0;

  booth_radix4_multiplier #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Issue one operation; lat counts edges from the accepting edge to done
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [31:0] p, output int lat);
    @(negedge clk);
    multiplicand = a; multiplier = b; signed_mode = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = 99;
    p = product;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; signed_mode = 1'b1;
    multiplicand = 16'h1234; multiplier = 16'h5678;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_signed_corner;
    logic [31:0] p; int lat;
    run_op(16'h8000, 16'h8000, 1'b1, p, lat);
    checks++; if (p !== 32'h4000_0000) begin errors++; $display("FAIL min_sq product got %h want 40000000", p); end
    checks++; if (lat != 10) begin errors++; $display("FAIL min_sq latency got %0d want 10 (9 edges after accept)", lat); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL min_sq ready_at_done got %b want 1", ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL min_sq done_width got %b want 0", done); end
    checks++; if (product !== 32'h4000_0000) begin errors++; $display("FAIL min_sq hold got %h want 40000000", product); end
  endtask

  task automatic test_vectors;
    logic [15:0] va [10] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h5678,
                             16'h0000, 16'hFFFF, 16'h7FFF, 16'h8001, 16'h8001};
    logic [15:0] vb [10] = '{16'hFFFF, 16'h0002, 16'h0002, 16'h1234, 16'h0000,
                             16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF, 16'hFFFF};
    logic        vs [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // 65535^2; -1*2; 65535*2; zeros; 32767*-32768; 32769*65535; -32767*-1
    logic [31:0] ve [10] = '{32'hFFFE_0001, 32'hFFFF_FFFE, 32'h0001_FFFE, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'hC000_8000, 32'h8000_7FFF, 32'h0000_7FFF};
    logic [31:0] p; int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vb[i], vs[i], p, lat);
      checks++;
      if (p !== ve[i] || lat != 10) begin
        errors++;
        $display("FAIL vec%0d %h*%h s=%b got %h lat=%0d want %h lat=10", i, va[i], vb[i], vs[i], p, lat, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    multiplicand = 16'd123; multiplier = -16'sd45; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b ready_calc got %b want 0", ready); end
    // start stays high with different operands during CALC: must be ignored
    multiplicand = 16'd100; multiplier = 16'd7;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (product !== 32'hFFFF_EA61 || lat != 10) begin
      errors++; $display("FAIL b2b first got %h lat=%0d want ffffea61 lat=10", product, lat);
    end
    // start still high in DONE: accepted on this edge
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL b2b accept got done=%b ready=%b want 0 0", done, ready);
    end
    checks++; if (product !== 32'hFFFF_EA61) begin errors++; $display("FAIL b2b hold got %h want ffffea61", product); end
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (product !== 32'h0000_02BC || lat != 10) begin
      errors++; $display("FAIL b2b second got %h lat=%0d want 000002bc lat=10", product, lat);
    end
  endtask

  task automatic test_reset_mid_calc;
    logic [31:0] p; int lat; int pulses;
    @(negedge clk);
    multiplicand = 16'h7FFF; multiplier = 16'h7FFF; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0 || product !== 32'h0) begin
      errors++; $display("FAIL midrst got ready=%b done=%b product=%h want 1 0 0", ready, done, product);
    end
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst stray_done got %0d pulses want 0", pulses); end
    run_op(16'hFFF9, 16'h0009, 1'b1, p, lat);  // -7 * 9 = -63
    checks++; if (p !== 32'hFFFF_FFC1 || lat != 10) begin
      errors++; $display("FAIL midrst fresh got %h lat=%0d want ffffffc1 lat=10", p, lat);
    end
  endtask

  initial begin
    test_reset();
    test_signed_corner();
    test_vectors();
    test_back_to_back();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
